input_handler: RTL
==================

# input_handler

Converts the five raw push-buttons of the clock board into the clean control stream consumed by the clock state storage block. It supplies single-cycle up, down and clear pulses and a one-hot cursor position. Each button is synchronized and debounced. Up/down auto-repeat while held. The centre button toggles edit mode on a short press and issues a clear on a long hold. The block sits between the board pins and the clock state storage block.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button change (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: hold time before the first auto-repeat (0.5 s).
- REPEAT_RATE, 10000000: period between subsequent auto-repeat pulses (0.1 s).
- CLEAR_HOLD, 200000000: centre hold time that triggers a clear (2 s).

Ports:
- clk  in  1  100 MHz onboard clock; the only clock.
- reset  in  1  synchronous, active-high block reset.
- btnUp, btnDown, btnLeft, btnRight, btnCenter  in  1 each  raw asynchronous button levels, active-high.
- up  out  1  single-cycle increment pulse.
- down  out  1  single-cycle decrement pulse.
- clearPulse  out  1  single-cycle clear-time pulse.
- cursorPos  out  3  one-hot field select: 000 = run mode (not editing), 001 = seconds, 010 = minutes, 100 = hours.

## Operation

- Each button passes through a 2-FF synchronizer and then the debouncer. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Press event = debounced rising edge. Release event = debounced falling edge.
- Left press, edit mode: cursor rotates toward hours: 001→010→100→001.
- Right press, edit mode: cursor rotates the opposite way: 001→100→010→001.
- Left/right presses in run mode are ignored.
- Left and right debounced-high together: neither acts.
- Up/down repeat FSM, states IDLE, DELAY, REPEAT:
  - IDLE→DELAY on a press; emits one pulse immediately.
  - DELAY→REPEAT after REPEAT_DELAY cycles held; emits a pulse on entry.
  - REPEAT emits a pulse every REPEAT_RATE cycles.
  - Release → IDLE from any state.
  - Up and down share one repeat counter.
  - Both up and down debounced-high: no pulses; FSM returns to IDLE.
  - In run mode (cursorPos = 000): no up/down pulses; FSM held in IDLE.
- Centre FSM, states IDLE, HELD, CLEARED:
  - IDLE→HELD on press; the hold counter is zeroed.
  - HELD→IDLE on release before CLEAR_HOLD. This toggles edit mode: run→001, any edit position→000.
  - HELD→CLEARED when the hold count reaches CLEAR_HOLD. clearPulse is high for exactly one cycle; cursor is unchanged.
  - CLEARED→IDLE on release, with no toggle.
  - Clear is available in both run and edit mode.
- Counters are unsigned, each sized to $clog2 of its parameter plus 1. They saturate and never wrap while a button is held.

## Timing

- Reset values: up = down = clearPulse = 0; cursorPos = 000. All FSMs are IDLE, all counters 0, and synchronizer and debounced levels are 0.
- Press latency: the first raw-high cycle is cycle 0. The pulse is high in cycle DEBOUNCE_CYCLES+3: 2 cycles synchronizer, DEBOUNCE_CYCLES debounce, 1 cycle registered edge.
- cursorPos updates in the same cycle a left/right pulse would appear.
- All outputs are registered; no combinational path from btn* to any output.
- Reset asserted mid-hold forces the reset values next cycle.
  - A button still held after reset is released must first be debounced high. Its press event then fires normally; the pre-reset press is not remembered.
- Exactly one of up/down can be high in any cycle. clearPulse can coincide with an up/down pulse.

## Structure

- Shared package holds:
  - cursor encodings CURSOR_RUN=3'b000, CURSOR_SEC=3'b001, CURSOR_MIN=3'b010, CURSOR_HOUR=3'b100, also used by the clock state storage block;
  - the repeat-FSM and centre-FSM state encodings.
- One natural sub-module: button_debouncer (synchronizer, debounce counter, press/release pulse outputs; parameter DEBOUNCE_CYCLES). It is instantiated five times.
- Repeat FSM, centre FSM and cursor register live in input_handler.

## Test plan

Simulation parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, CLEAR_HOLD=40.
- Reset, then idle 50 cycles → all outputs 0, cursorPos = 000.
- Centre tapped 10 cycles with no bounce → cursorPos 000→001 at press+release latency. Left pressed three times → 010, 100, 001. Right pressed once → 100.
- In edit mode, up toggles 0/1 every cycle for 3 cycles, then stays high 60 cycles:
  - one up pulse at cycle 7 after the stable high;
  - next pulse 20 cycles later;
  - then pulses every 5 cycles;
  - no pulses after release.
- Up and down held together in edit mode → up = down = 0 throughout.
- In run mode, centre held 60 cycles → exactly one clearPulse 40 cycles after the debounced press, cursorPos still 000, no toggle on release.
- Up held in run mode → no up pulse. Reset asserted mid-repeat → all outputs 0 next cycle, cursorPos = 000.

Source files
------------

// File: rtl/input_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_handler_pkg
// Purpose  : Shared cursor encodings, button indices and FSM state encodings
//            for the push-button front end of the clock board.
// Revision : 1.0 - initial release
// ============================================================================
package input_handler_pkg;

    // One-hot field select, shared with the clock state storage block
    localparam logic [2:0] CURSOR_RUN  = 3'b000;
    localparam logic [2:0] CURSOR_SEC  = 3'b001;
    localparam logic [2:0] CURSOR_MIN  = 3'b010;
    localparam logic [2:0] CURSOR_HOUR = 3'b100;

    // Bit positions of the buttons inside the debounced vectors
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int BTN_COUNT  = 5;

    // Up/down auto-repeat FSM
    localparam logic [1:0] REP_IDLE   = 2'd0;
    localparam logic [1:0] REP_DELAY  = 2'd1;
    localparam logic [1:0] REP_REPEAT = 2'd2;

    // Centre button FSM
    localparam logic [1:0] CTR_IDLE    = 2'd0;
    localparam logic [1:0] CTR_HELD    = 2'd1;
    localparam logic [1:0] CTR_CLEARED = 2'd2;

    // Cursor moves toward hours: sec -> min -> hour -> sec
    function automatic logic [2:0] rotateLeft(input logic [2:0] cur);
        return {cur[1:0], cur[2]};
    endfunction

    // Cursor moves toward seconds: sec -> hour -> min -> sec
    function automatic logic [2:0] rotateRight(input logic [2:0] cur);
        return {cur[0], cur[2:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : 2-FF synchronizer plus stable-count debouncer for one raw button.
//            Provides the debounced level and one-cycle press/release strobes
//            (strobes are combinational from the registered level).
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_levelPrev;
    logic [c_CNT_W-1:0] r_count;

    // Synchronize, then accept a new level only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_level     <= 1'b0;
            r_levelPrev <= 1'b0;
            r_count     <= '0;
        end else begin
            r_sync1     <= btnRaw;
            r_sync2     <= r_sync1;
            r_levelPrev <= r_level;
            if (r_sync2 != r_level) begin
                if (r_count >= c_CNT_LAST) begin
                    r_level <= r_sync2;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                // Any bounce back to the accepted level restarts the count
                r_count <= '0;
            end
        end
    end

    assign level    = r_level;
    assign pressed  = r_level & ~r_levelPrev;
    assign released = ~r_level & r_levelPrev;

endmodule
`default_nettype wire

// File: rtl/input_handler.sv
`default_nettype none
// ============================================================================
// Module   : input_handler
// Purpose  : Turns the five raw board buttons into registered up/down/clear
//            pulses and a one-hot cursor for the clock state storage block.
//            Up/down auto-repeat; centre toggles edit mode or clears on hold.
// Revision : 1.0 - initial release
// ============================================================================
module input_handler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CLEAR_HOLD      = 200000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnCenter,
    output logic       up,
    output logic       down,
    output logic       clearPulse,
    output logic [2:0] cursorPos
);

    import input_handler_pkg::*;

    // Up and down share one counter, so it is sized for the longer interval
    localparam int c_REP_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W    = $clog2(c_REP_MAX) + 1;
    localparam int c_HOLD_W   = $clog2(CLEAR_HOLD) + 1;
    localparam logic [c_REP_W-1:0]  c_DELAY_LAST = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0]  c_RATE_LAST  = c_REP_W'(REPEAT_RATE - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'(CLEAR_HOLD - 1);

    logic [BTN_COUNT-1:0] w_btnRaw;
    logic [BTN_COUNT-1:0] w_level;
    logic [BTN_COUNT-1:0] w_pressed;
    logic [BTN_COUNT-1:0] w_released;
    logic                 w_unusedReleased;

    assign w_btnRaw = {btnCenter, btnRight, btnLeft, btnDown, btnUp};

    generate
        for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk     (clk),
                .reset   (reset),
                .btnRaw  (w_btnRaw[i]),
                .level   (w_level[i]),
                .pressed (w_pressed[i]),
                .released(w_released[i])
            );
        end
    endgenerate

    // Release strobes are not needed: every FSM exits on the debounced level
    assign w_unusedReleased = ^w_released;

    logic                r_up, r_down, r_clearPulse;
    logic [2:0]          r_cursorPos;
    logic [1:0]          r_repState, w_repNext;
    logic                r_repUp;
    logic [c_REP_W-1:0]  r_repCount;
    logic [1:0]          r_ctrState, w_ctrNext;
    logic [c_HOLD_W-1:0] r_holdCount;

    logic w_editing, w_upOnly, w_downOnly, w_startUp, w_repHeld;
    logic w_repFire, w_repRestart, w_toggle, w_clearNow;

    assign w_editing  = (r_cursorPos != CURSOR_RUN);
    assign w_upOnly   = w_level[BTN_UP] & ~w_level[BTN_DOWN];
    assign w_downOnly = w_level[BTN_DOWN] & ~w_level[BTN_UP];
    assign w_startUp  = w_pressed[BTN_UP] & w_upOnly;
    assign w_repHeld  = r_repUp ? w_upOnly : w_downOnly;

    // Repeat FSM next state: any release, double press or run mode drops to idle
    always_comb begin
        w_repNext = r_repState;
        case (r_repState)
            REP_IDLE: begin
                if (w_editing && (w_startUp || (w_pressed[BTN_DOWN] && w_downOnly)))
                    w_repNext = REP_DELAY;
            end
            REP_DELAY: begin
                if (!w_editing || !w_repHeld)
                    w_repNext = REP_IDLE;
                else if (r_repCount >= c_DELAY_LAST)
                    w_repNext = REP_REPEAT;
            end
            REP_REPEAT: begin
                if (!w_editing || !w_repHeld)
                    w_repNext = REP_IDLE;
            end
            default: w_repNext = REP_IDLE;
        endcase
    end

    // Repeat FSM outputs: fire on entry to DELAY/REPEAT and each rate period
    always_comb begin
        w_repFire    = 1'b0;
        w_repRestart = 1'b0;
        case (r_repState)
            REP_IDLE:   w_repFire = (w_repNext == REP_DELAY);
            REP_DELAY:  w_repFire = (w_repNext == REP_REPEAT);
            REP_REPEAT: w_repFire = (w_repNext == REP_REPEAT) && (r_repCount >= c_RATE_LAST);
            default:    w_repFire = 1'b0;
        endcase
        w_repRestart = w_repFire;
    end

    // Centre FSM next state: short press toggles edit mode, long hold clears
    always_comb begin
        w_ctrNext = r_ctrState;
        case (r_ctrState)
            CTR_IDLE: begin
                if (w_pressed[BTN_CENTER])
                    w_ctrNext = CTR_HELD;
            end
            CTR_HELD: begin
                if (!w_level[BTN_CENTER])
                    w_ctrNext = CTR_IDLE;
                else if (r_holdCount >= c_HOLD_LAST)
                    w_ctrNext = CTR_CLEARED;
            end
            CTR_CLEARED: begin
                if (!w_level[BTN_CENTER])
                    w_ctrNext = CTR_IDLE;
            end
            default: w_ctrNext = CTR_IDLE;
        endcase
    end

    // Centre FSM outputs: toggle only on a release from HELD
    always_comb begin
        w_toggle   = (r_ctrState == CTR_HELD) && (w_ctrNext == CTR_IDLE);
        w_clearNow = (r_ctrState == CTR_HELD) && (w_ctrNext == CTR_CLEARED);
    end

    // State registers, saturating counters, cursor and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_repState   <= REP_IDLE;
            r_repUp      <= 1'b0;
            r_repCount   <= '0;
            r_ctrState   <= CTR_IDLE;
            r_holdCount  <= '0;
            r_cursorPos  <= CURSOR_RUN;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_clearPulse <= 1'b0;
        end else begin
            r_repState <= w_repNext;
            if (r_repState == REP_IDLE)
                r_repUp <= w_startUp;
            if (w_repRestart || (w_repNext == REP_IDLE))
                r_repCount <= '0;
            else if (r_repCount != '1)
                r_repCount <= r_repCount + 1'b1;

            r_ctrState <= w_ctrNext;
            if (r_ctrState != CTR_HELD)
                r_holdCount <= '0;
            else if (r_holdCount != '1)
                r_holdCount <= r_holdCount + 1'b1;

            if (w_toggle)
                r_cursorPos <= w_editing ? CURSOR_RUN : CURSOR_SEC;
            else if (w_editing && w_pressed[BTN_LEFT] && !w_level[BTN_RIGHT])
                r_cursorPos <= rotateLeft(r_cursorPos);
            else if (w_editing && w_pressed[BTN_RIGHT] && !w_level[BTN_LEFT])
                r_cursorPos <= rotateRight(r_cursorPos);

            r_up         <= w_repFire & ((r_repState == REP_IDLE) ? w_startUp : r_repUp);
            r_down       <= w_repFire & ((r_repState == REP_IDLE) ? ~w_startUp : ~r_repUp);
            r_clearPulse <= w_clearNow;
        end
    end

    assign up         = r_up;
    assign down       = r_down;
    assign clearPulse = r_clearPulse;
    assign cursorPos  = r_cursorPos;

endmodule
`default_nettype wire
